// File: rtl/sobel_window_ctrl.sv
// Sequences one frame of raster pixels into 3x3 Sobel neighbourhoods using two
// line buffers; emits the eight outer taps through a registered valid/ready stage.
module sobel_window_ctrl #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          in_ready_o,
    output logic          win_valid_o,
    input  logic          win_ready_i,
    output logic [DW-1:0] p0_o,
    output logic [DW-1:0] p1_o,
    output logic [DW-1:0] p2_o,
    output logic [DW-1:0] p3_o,
    output logic [DW-1:0] p5_o,
    output logic [DW-1:0] p6_o,
    output logic [DW-1:0] p7_o,
    output logic [DW-1:0] p8_o,
    output logic          busy_o,
    output logic          frame_done_o
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q;
    logic             frame_done_q;
    logic [DW-1:0]    p0_q, p1_q, p2_q, p3_q, p5_q, p6_q, p7_q, p8_q;

    logic [DW-1:0]    lb1_q [IMG_W];
    logic [DW-1:0]    lb2_q [IMG_W];
    // Two previous window columns, [2]=top [1]=mid [0]=bottom
    logic [2:0][DW-1:0] colm2_q;
    logic [2:0][DW-1:0] colm1_q;

    logic             accept;
    logic             load;
    logic             last_px;
    logic [DW-1:0]    lb_top;
    logic [DW-1:0]    lb_mid;

    assign in_ready_o = (state_q == RUN) && (!win_valid_q || win_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign lb_top     = lb2_q[col_q];
    assign lb_mid     = lb1_q[col_q];
    assign last_px    = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
    assign load       = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    // Raster position advance
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = last_px ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Control FSM, counters and registered output stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            p3_q         <= '0;
            p5_q         <= '0;
            p6_q         <= '0;
            p7_q         <= '0;
            p8_q         <= '0;
        end else begin
            frame_done_q <= 1'b0;
            row_q        <= row_d;
            col_q        <= col_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                RUN: begin
                    if (accept && last_px) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!win_valid_q || win_ready_i) begin
                        state_q      <= IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A newly loaded window takes priority over a same-cycle consume
            if (load) begin
                win_valid_q <= 1'b1;
                p0_q        <= colm2_q[2];
                p1_q        <= colm1_q[2];
                p2_q        <= lb_top;
                p3_q        <= colm2_q[1];
                p5_q        <= lb_mid;
                p6_q        <= colm2_q[0];
                p7_q        <= colm1_q[0];
                p8_q        <= in_data_i;
            end else if (win_ready_i) begin
                win_valid_q <= 1'b0;
            end
        end
    end

    // Line buffers and column history carry no reset
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1_q[col_q] <= in_data_i;
            lb2_q[col_q] <= lb1_q[col_q];
            colm2_q      <= colm1_q;
            colm1_q      <= {lb_top, lb_mid, in_data_i};
        end
    end

    assign win_valid_o  = win_valid_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != IDLE);
    assign p0_o         = p0_q;
    assign p1_o         = p1_q;
    assign p2_o         = p2_q;
    assign p3_o         = p3_q;
    assign p5_o         = p5_q;
    assign p6_o         = p6_q;
    assign p7_o         = p7_q;
    assign p8_o         = p8_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: a 4x4 instance and a 5x3 instance.
module tb_sobel_window_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: 4x4
    logic       a_start, a_in_valid, a_in_ready, a_win_valid, a_win_ready, a_busy, a_frame_done;
    logic [7:0] a_in_data, a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8;
    logic [63:0] a_taps;
    assign a_taps = {a_p0, a_p1, a_p2, a_p3, a_p5, a_p6, a_p7, a_p8};

    // Instance B: 5x3
    logic       b_start, b_in_valid, b_in_ready, b_win_valid, b_win_ready, b_busy, b_frame_done;
    logic [7:0] b_in_data, b_p0, b_p1, b_p2, b_p3, b_p5, b_p6, b_p7, b_p8;
    logic [63:0] b_taps;
    assign b_taps = {b_p0, b_p1, b_p2, b_p3, b_p5, b_p6, b_p7, b_p8};

    sobel_window_ctrl #(.IMG_W(4), .IMG_H(4), .DW(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start),
        .in_valid_i(a_in_valid), .in_data_i(a_in_data), .in_ready_o(a_in_ready),
        .win_valid_o(a_win_valid), .win_ready_i(a_win_ready),
        .p0_o(a_p0), .p1_o(a_p1), .p2_o(a_p2), .p3_o(a_p3),
        .p5_o(a_p5), .p6_o(a_p6), .p7_o(a_p7), .p8_o(a_p8),
        .busy_o(a_busy), .frame_done_o(a_frame_done)
    );

    sobel_window_ctrl #(.IMG_W(5), .IMG_H(3), .DW(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start),
        .in_valid_i(b_in_valid), .in_data_i(b_in_data), .in_ready_o(b_in_ready),
        .win_valid_o(b_win_valid), .win_ready_i(b_win_ready),
        .p0_o(b_p0), .p1_o(b_p1), .p2_o(b_p2), .p3_o(b_p3),
        .p5_o(b_p5), .p6_o(b_p6), .p7_o(b_p7), .p8_o(b_p8),
        .busy_o(b_busy), .frame_done_o(b_frame_done)
    );

    // Hand-computed windows for pixel = 16*row + col, order {p0,p1,p2,p3,p5,p6,p7,p8}
    logic [63:0] exp_a [4] = '{64'h00_01_02_10_12_20_21_22,
                               64'h01_02_03_11_13_21_22_23,
                               64'h10_11_12_20_22_30_31_32,
                               64'h11_12_13_21_23_31_32_33};
    logic [63:0] exp_b [3] = '{64'h00_01_02_10_12_20_21_22,
                               64'h01_02_03_11_13_21_22_23,
                               64'h02_03_04_12_14_22_23_24};

    // Observation of handshakes, sampled on the falling edge
    logic [63:0] win_a [$];
    logic [63:0] win_b [$];
    int acc_a = 0, fd_a = 0, acc34_a = -1, first_win_a = -1;
    int acc_b = 0, fd_b = 0;

    always @(negedge clk) begin
        if (a_win_valid === 1'b1 && a_win_ready === 1'b1) win_a.push_back(a_taps);
        if (a_win_valid === 1'b1 && first_win_a < 0) first_win_a = cyc_n;
        if (a_in_valid === 1'b1 && a_in_ready === 1'b1) begin
            acc_a++;
            if (a_in_data == 8'd34) acc34_a = cyc_n;
        end
        if (a_frame_done === 1'b1) fd_a++;
        if (b_win_valid === 1'b1 && b_win_ready === 1'b1) win_b.push_back(b_taps);
        if (b_in_valid === 1'b1 && b_in_ready === 1'b1) acc_b++;
        if (b_frame_done === 1'b1) fd_b++;
    end

    function automatic logic [7:0] pix(input int idx, input int w);
        return 8'(16 * (idx / w) + (idx % w));
    endfunction

    task automatic clear_a();
        win_a.delete();
        acc_a = 0; fd_a = 0; acc34_a = -1; first_win_a = -1;
    endtask

    task automatic start_a();
        @(posedge clk); #1;
        a_start = 1'b1;
    endtask

    // Feeds pixels 0..stop_after-1; start re-pulsed while idx == restart_at
    task automatic drive_a(input bit toggle, input int restart_at, input int stop_after, output bit ok);
        int idx = 0;
        int n = 0;
        while (idx < stop_after && n < 400) begin
            @(posedge clk); #1;
            a_start     = (idx == restart_at);
            a_in_valid  = toggle ? (n % 2 == 0) : 1'b1;
            a_in_data   = pix(idx, 4);
            a_win_ready = 1'b1;
            @(negedge clk);
            if (a_in_valid && a_in_ready) idx++;
            n++;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_start    = 1'b0;
        ok = (idx == stop_after);
    endtask

    task automatic wait_idle_a(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (a_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b1;
        b_in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (a_win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %b, expected 0", a_win_valid); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", a_busy); end
        n_checks++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", a_frame_done); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 0", a_in_ready); end
        n_checks++; if (a_taps !== 64'h0) begin n_fail++; $display("FAIL reset_taps: got %h, expected 0", a_taps); end
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b, expected 0", b_busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic test_stream();
        bit ok;
        clear_a();
        start_a();
        drive_a(1'b0, -1, 16, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_feed_timeout: got %b, expected 1", ok); end
        wait_idle_a(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stream_idle_timeout: got %b, expected 1", ok); end
        n_checks++; if (win_a.size() != 4) begin n_fail++; $display("FAIL stream_win_count: got %0d, expected 4", win_a.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [63:0] got;
            got = (i < win_a.size()) ? win_a[i] : 64'hx;
            n_checks++; if (got !== exp_a[i]) begin n_fail++; $display("FAIL stream_win%0d: got %h, expected %h", i, got, exp_a[i]); end
        end
        n_checks++; if (first_win_a != acc34_a + 1) begin n_fail++; $display("FAIL stream_latency: got cycle %0d, expected %0d", first_win_a, acc34_a + 1); end
        n_checks++; if (fd_a != 1) begin n_fail++; $display("FAIL stream_frame_done: got %0d, expected 1", fd_a); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy: got %b, expected 0", a_busy); end
        n_checks++; if (acc_a != 16) begin n_fail++; $display("FAIL stream_accepts: got %0d, expected 16", acc_a); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int idx = 0;
        int st = 0;
        int n = 0;
        clear_a();
        start_a();
        while (idx < 16 && n < 400) begin
            @(posedge clk); #1;
            a_start     = 1'b0;
            a_in_valid  = 1'b1;
            a_in_data   = pix(idx, 4);
            a_win_ready = !(a_win_valid === 1'b1 && st < 5);
            @(negedge clk);
            if (!a_win_ready) begin
                st++;
                n_checks++; if (a_win_valid !== 1'b1) begin n_fail++; $display("FAIL bp_win_valid: got %b, expected 1", a_win_valid); end
                n_checks++; if (a_taps !== exp_a[0]) begin n_fail++; $display("FAIL bp_taps_frozen: got %h, expected %h", a_taps, exp_a[0]); end
                n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, expected 0", a_in_ready); end
            end
            if (a_in_valid && a_in_ready) idx++;
            n++;
        end
        @(posedge clk); #1;
        a_in_valid  = 1'b0;
        a_win_ready = 1'b1;
        wait_idle_a(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_idle_timeout: got %b, expected 1", ok); end
        n_checks++; if (st != 5) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d, expected 5", st); end
        n_checks++; if (win_a.size() != 4) begin n_fail++; $display("FAIL bp_win_count: got %0d, expected 4", win_a.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [63:0] got;
            got = (i < win_a.size()) ? win_a[i] : 64'hx;
            n_checks++; if (got !== exp_a[i]) begin n_fail++; $display("FAIL bp_win%0d: got %h, expected %h", i, got, exp_a[i]); end
        end
        n_checks++; if (acc_a != 16) begin n_fail++; $display("FAIL bp_accepts: got %0d, expected 16", acc_a); end
        n_checks++; if (fd_a != 1) begin n_fail++; $display("FAIL bp_frame_done: got %0d, expected 1", fd_a); end
    endtask

    task automatic test_toggle();
        int idx = 0;
        int n = 0;
        bit idle = 1'b0;
        win_b.delete();
        acc_b = 0; fd_b = 0;
        @(posedge clk); #1;
        b_start = 1'b1;
        while (idx < 15 && n < 400) begin
            @(posedge clk); #1;
            b_start     = 1'b0;
            b_in_valid  = (n % 2 == 0);
            b_in_data   = pix(idx, 5);
            b_win_ready = 1'b1;
            @(negedge clk);
            if (b_in_valid && b_in_ready) idx++;
            n++;
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b_busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        n_checks++; if (!idle) begin n_fail++; $display("FAIL toggle_idle_timeout: got %b, expected 1", idle); end
        n_checks++; if (win_b.size() != 3) begin n_fail++; $display("FAIL toggle_win_count: got %0d, expected 3", win_b.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [63:0] got;
            got = (i < win_b.size()) ? win_b[i] : 64'hx;
            n_checks++; if (got !== exp_b[i]) begin n_fail++; $display("FAIL toggle_win%0d: got %h, expected %h", i, got, exp_b[i]); end
        end
        n_checks++; if (acc_b != 15) begin n_fail++; $display("FAIL toggle_accepts: got %0d, expected 15", acc_b); end
        n_checks++; if (fd_b != 1) begin n_fail++; $display("FAIL toggle_frame_done: got %0d, expected 1", fd_b); end
    endtask

    task automatic test_abort();
        bit ok;
        clear_a();
        start_a();
        drive_a(1'b0, -1, 9, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_feed_timeout: got %b, expected 1", ok); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, expected 0", a_busy); end
        n_checks++; if (a_win_valid !== 1'b0) begin n_fail++; $display("FAIL abort_win_valid: got %b, expected 0", a_win_valid); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (fd_a != 0) begin n_fail++; $display("FAIL abort_frame_done: got %0d, expected 0", fd_a); end
        n_checks++; if (win_a.size() != 0) begin n_fail++; $display("FAIL abort_win_count: got %0d, expected 0", win_a.size()); end
        n_checks++; if (acc_a != 9) begin n_fail++; $display("FAIL abort_accepts: got %0d, expected 9", acc_a); end
        clear_a();
        start_a();
        drive_a(1'b0, -1, 16, ok);
        wait_idle_a(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort2_idle_timeout: got %b, expected 1", ok); end
        n_checks++; if (win_a.size() != 4) begin n_fail++; $display("FAIL abort2_win_count: got %0d, expected 4", win_a.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [63:0] got;
            got = (i < win_a.size()) ? win_a[i] : 64'hx;
            n_checks++; if (got !== exp_a[i]) begin n_fail++; $display("FAIL abort2_win%0d: got %h, expected %h", i, got, exp_a[i]); end
        end
        n_checks++; if (fd_a != 1) begin n_fail++; $display("FAIL abort2_frame_done: got %0d, expected 1", fd_a); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        clear_a();
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_data  = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b, expected 0", a_in_ready); end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_checks++; if (acc_a != 0) begin n_fail++; $display("FAIL idle_accepts: got %0d, expected 0", acc_a); end
        start_a();
        drive_a(1'b0, 6, 16, ok);
        wait_idle_a(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_idle_timeout: got %b, expected 1", ok); end
        n_checks++; if (win_a.size() != 4) begin n_fail++; $display("FAIL restart_win_count: got %0d, expected 4", win_a.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [63:0] got;
            got = (i < win_a.size()) ? win_a[i] : 64'hx;
            n_checks++; if (got !== exp_a[i]) begin n_fail++; $display("FAIL restart_win%0d: got %h, expected %h", i, got, exp_a[i]); end
        end
        n_checks++; if (acc_a != 16) begin n_fail++; $display("FAIL restart_accepts: got %0d, expected 16", acc_a); end
        n_checks++; if (fd_a != 1) begin n_fail++; $display("FAIL restart_frame_done: got %0d, expected 1", fd_a); end
    endtask

    task automatic test_flush_hold();
        bit ok;
        clear_a();
        start_a();
        drive_a(1'b0, -1, 16, ok);
        a_win_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL flush_hold_done: got %b, expected 0", a_frame_done); end
            n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL flush_hold_busy: got %b, expected 1", a_busy); end
            n_checks++; if (a_taps !== exp_a[3]) begin n_fail++; $display("FAIL flush_hold_taps: got %h, expected %h", a_taps, exp_a[3]); end
            @(posedge clk); #1;
        end
        a_win_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL flush_release_done0: got %b, expected 0", a_frame_done); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (a_frame_done !== 1'b1) begin n_fail++; $display("FAIL flush_release_done1: got %b, expected 1", a_frame_done); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL flush_release_busy: got %b, expected 0", a_busy); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (a_frame_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_pulse_width: got %b, expected 0", a_frame_done); end
        @(posedge clk); #1;
        n_checks++; if (fd_a != 1) begin n_fail++; $display("FAIL flush_done_count: got %0d, expected 1", fd_a); end
        n_checks++; if (win_a.size() != 4) begin n_fail++; $display("FAIL flush_win_count: got %0d, expected 4", win_a.size()); end
    endtask

    initial begin
        a_start = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_win_ready = 1'b1;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_win_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_abort();
        test_start_ignored();
        test_flush_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
